// File: rtl/stack_ctrl.sv
// stack_ctrl: expands stack opcodes into {update,push,pop} command sequences
// for the cached data stack. Depth and error checking under STACK_CTRL_CHECK_EN.
// Ports: clk, reset_n (async, active-low); op_valid/op_ready/op_code/op_imm
//   opcode handshake; stk_cmd/stk_in/stk_s0 stack side; busy, depth,
//   err/err_code/err_clr status.
module stack_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int DEPTH_MAX = 2**AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_code,
  input  logic [DW-1:0] op_imm,
  output logic [2:0]    stk_cmd,
  output logic [DW-1:0] stk_in,
  input  logic [DW-1:0] stk_s0,
  output logic          busy,
  output logic [AW:0]   depth,
  output logic          err,
  output logic [1:0]    err_code,
  input  logic          err_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EX1  = 2'd1;
  localparam logic [1:0] EX2  = 2'd2;
  localparam logic [1:0] EX3  = 2'd3;

  localparam logic [3:0] OP_LIT  = 4'd1;
  localparam logic [3:0] OP_DUP  = 4'd2;
  localparam logic [3:0] OP_DROP = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] t_q, t_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] alu;
  logic          accept;
  logic          reject;
  logic          q_lit, q_dup, q_drop, q_swap, q_bin;

  assign op_ready = (state_q == IDLE);
  assign busy     = ~op_ready;
  assign accept   = op_valid & op_ready;

  assign q_lit  = (op_q == OP_LIT);
  assign q_dup  = (op_q == OP_DUP);
  assign q_drop = (op_q == OP_DROP);
  assign q_swap = (op_q == OP_SWAP);
  assign q_bin  = (op_q >= OP_ADD) && (op_q <= OP_XOR);

  // Operands: stk_s0 is NOS (after the pop in EX1), t_q is the old TOS.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = stk_s0 + t_q;
      OP_SUB:  alu = stk_s0 - t_q;
      OP_AND:  alu = stk_s0 & t_q;
      OP_OR:   alu = stk_s0 | t_q;
      OP_XOR:  alu = stk_s0 ^ t_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    t_d     = t_q;
    r_d     = r_q;
    stk_cmd = 3'b000;
    stk_in  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op_code;
          imm_d = op_imm;
          if (!reject) state_d = EX1;
        end
      end
      EX1: begin
        unique case (1'b1)
          q_lit: begin
            stk_cmd = 3'b110;
            stk_in  = imm_q;
          end
          q_dup: begin
            stk_cmd = 3'b110;
            stk_in  = stk_s0;
          end
          q_drop: stk_cmd = 3'b001;
          q_bin, q_swap: begin
            stk_cmd = 3'b001;
            t_d     = stk_s0;
          end
          default: stk_cmd = 3'b000;
        endcase
        state_d = (q_bin | q_swap) ? EX2 : IDLE;
      end
      EX2: begin
        stk_cmd = 3'b100;
        if (q_swap) begin
          stk_in  = t_q;
          r_d     = stk_s0;
          state_d = EX3;
        end else begin
          stk_in  = alu;
          state_d = IDLE;
        end
      end
      EX3: begin
        stk_cmd = 3'b110;
        stk_in  = r_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      t_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      t_q     <= t_d;
      r_q     <= r_d;
    end
  end

`ifdef STACK_CTRL_CHECK_EN
  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH_MAX);

  logic [AW:0] depth_q, depth_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        need1, need2, grows, ill;
  logic        uflow, oflow;
  logic [1:0]  new_code;

  // Checks look at the incoming opcode, before it is latched.
  assign need1 = (op_code == OP_DUP) | (op_code == OP_DROP);
  assign need2 = (op_code >= OP_SWAP) & (op_code <= OP_XOR);
  assign grows = (op_code == OP_LIT) | (op_code == OP_DUP);
  assign ill   = (op_code > OP_XOR);

  assign uflow = (need1 & (depth_q == '0)) |
                 (need2 & (depth_q < (AW+1)'(2)));
  assign oflow = grows & (depth_q == DMAX);

  always_comb begin
    new_code = 2'd0;
    unique case (1'b1)
      uflow:   new_code = 2'd1;
      oflow:   new_code = 2'd2;
      ill:     new_code = 2'd3;
      default: new_code = 2'd0;
    endcase
  end

  assign reject = uflow | oflow;

  always_comb begin
    depth_d = depth_q;
    if (stk_cmd[1] & ~stk_cmd[0]) depth_d = depth_q + (AW+1)'(1);
    if (stk_cmd[0] & ~stk_cmd[1]) depth_d = depth_q - (AW+1)'(1);
  end

  // A new error arriving with err_clr wins; otherwise the first code sticks.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (err_clr) begin
      err_d  = 1'b0;
      code_d = 2'd0;
    end
    if (accept && new_code != 2'd0) begin
      err_d = 1'b1;
      if (!err_q || err_clr) code_d = new_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      depth_q <= depth_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign depth    = depth_q;
  assign err      = err_q;
  assign err_code = code_q;
`else
  logic unused_clr;

  assign reject     = 1'b0;
  assign depth      = '0;
  assign err        = 1'b0;
  assign err_code   = 2'd0;
  assign unused_clr = err_clr;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with a behavioural data stack
// answering stk_cmd and driving stk_s0.
module tb_stack_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef STACK_CTRL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_code;
  logic [DW-1:0] op_imm;
  logic [2:0]    stk_cmd;
  logic [DW-1:0] stk_in;
  logic [DW-1:0] stk_s0;
  logic          busy;
  logic [AW:0]   depth;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr;

  stack_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm),
    .stk_cmd(stk_cmd), .stk_in(stk_in), .stk_s0(stk_s0),
    .busy(busy), .depth(depth),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:63];
  logic [2:0]    cmd_log [0:255];
  int sp;
  int cmd_n;
  int hs_n;
  int n_cmp;
  int n_bad;

  assign stk_s0 = (sp > 0) ? mem[sp-1] : '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= 0;
    end else begin
      if (op_valid && op_ready) hs_n <= hs_n + 1;
      if (stk_cmd != 3'b000) begin
        cmd_log[cmd_n[7:0]] <= stk_cmd;
        cmd_n <= cmd_n + 1;
      end
      if (stk_cmd[0]) begin
        if (sp > 0) sp <= sp - 1;
      end else if (stk_cmd[1]) begin
        if (sp < 64) begin
          mem[sp] <= stk_in;
          sp <= sp + 1;
        end
      end else if (stk_cmd[2] && sp > 0) begin
        mem[sp-1] <= stk_in;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [DW-1:0] i);
    int k;
    k = 0;
    @(negedge clk);
    while (!op_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!op_ready) check("ready_timeout", op_ready, 1);
    op_valid = 1'b1;
    op_code  = c;
    op_imm   = i;
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 4'($urandom);
    op_imm   = DW'($urandom);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) check("busy_timeout", busy, 0);
  endtask

  task automatic run(input logic [3:0] c, input logic [DW-1:0] i,
                     output int cyc);
    issue(c, i);
    wait_idle(cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cyc, c0, h0, idx, bad_rdy, ex_seen;
    logic [3:0]    q_op  [0:3];
    logic [DW-1:0] q_imm [0:3];
    n_cmp = 0;
    n_bad = 0;
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op_code  = '0;
    op_imm   = '0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_cmd", stk_cmd, 0);
    check("rst_in", stk_in, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", op_ready, 1);
    check("rst_depth", depth, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);

    // DUP on an empty stack
    c0 = cmd_n;
    run(4'd2, 0, cyc);
    check("uf_cmds", cmd_n - c0, CHK ? 0 : 1);
    check("uf_cyc", cyc, CHK ? 0 : 1);
    check("uf_err", err, CHK);
    check("uf_code", err_code, CHK ? 1 : 0);
    check("uf_depth", depth, 0);
    run(4'd1, 16'd7, cyc);
    check("lit7_s0", stk_s0, 7);
    check("lit7_depth", depth, CHK ? 1 : 0);
    check("err_sticky", err, CHK);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err, 0);
    check("clr_code", err_code, 0);

    // illegal opcode runs as NOP, then a later underflow keeps code 3
    c0 = cmd_n;
    run(4'hB, 16'h1234, cyc);
    check("ill_cyc", cyc, 1);
    check("ill_cmds", cmd_n - c0, 0);
    check("ill_code", err_code, CHK ? 3 : 0);
    run(4'd6, 0, cyc);
    check("first_code", err_code, CHK ? 3 : 0);
    check("first_err", err, CHK);
    do_reset();
    check("rst2_err", err, 0);
    check("rst2_sp", sp, 0);

    // LIT 5, LIT 3, ADD
    c0 = cmd_n;
    run(4'd1, 16'd5, cyc);
    check("lit_cyc", cyc, 1);
    run(4'd1, 16'd3, cyc);
    run(4'd5, 0, cyc);
    check("add_cyc", cyc, 2);
    check("add_ncmd", cmd_n - c0, 4);
    check("trace0", cmd_log[(c0 + 0) % 256], 3'b110);
    check("trace1", cmd_log[(c0 + 1) % 256], 3'b110);
    check("trace2", cmd_log[(c0 + 2) % 256], 3'b001);
    check("trace3", cmd_log[(c0 + 3) % 256], 3'b100);
    check("add_s0", stk_s0, 8);
    check("add_depth", depth, CHK ? 1 : 0);

    // SUB wraps, bitwise ops, ADD wraps
    run(4'd1, 16'd0, cyc);
    run(4'd1, 16'd1, cyc);
    run(4'd6, 0, cyc);
    check("sub_s0", stk_s0, 16'hFFFF);
    run(4'd1, 16'h00F0, cyc);
    run(4'd1, 16'h0FF0, cyc);
    run(4'd9, 0, cyc);
    check("xor_s0", stk_s0, 16'h0F00);
    run(4'd1, 16'h00FF, cyc);
    run(4'd7, 0, cyc);
    check("and_s0", stk_s0, 16'h0000);
    run(4'd1, 16'h1234, cyc);
    run(4'd8, 0, cyc);
    check("or_s0", stk_s0, 16'h1234);
    run(4'd1, 16'hFFFF, cyc);
    run(4'd1, 16'd2, cyc);
    run(4'd5, 0, cyc);
    check("addw_s0", stk_s0, 16'h0001);
    check("alu_sp", sp, 4);
    check("alu_depth", depth, CHK ? 4 : 0);

    // SWAP then DROP
    run(4'd1, 16'd1, cyc);
    run(4'd1, 16'd2, cyc);
    run(4'd4, 0, cyc);
    check("swap_cyc", cyc, 3);
    check("swap_s0", stk_s0, 1);
    check("swap_nos", mem[sp-2], 2);
    issue(4'd3, 16'hABCD);
    check("drop_cmd", stk_cmd, 3'b001);
    check("drop_in", stk_in, 0);
    wait_idle(cyc);
    check("drop_s0", stk_s0, 2);
    check("drop_depth", depth, CHK ? 5 : 0);

    // op_valid held high across four back-to-back ops
    q_op[0] = 4'd1; q_imm[0] = 16'd10;
    q_op[1] = 4'd1; q_imm[1] = 16'd20;
    q_op[2] = 4'd5; q_imm[2] = 16'h5555;
    q_op[3] = 4'd2; q_imm[3] = 16'hAAAA;
    h0 = hs_n;
    idx = 0;
    bad_rdy = 0;
    ex_seen = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = q_op[0];
    op_imm   = q_imm[0];
    for (int k = 0; k < 40 && idx < 4; k++) begin
      @(negedge clk);
      if (busy) ex_seen++;
      if (busy && op_ready) bad_rdy++;
      if (hs_n - h0 != idx) begin
        idx = hs_n - h0;
        if (idx < 4) begin
          op_code = q_op[idx];
          op_imm  = q_imm[idx];
        end else begin
          op_valid = 1'b0;
        end
      end
    end
    op_valid = 1'b0;
    wait_idle(cyc);
    check("q_hs", hs_n - h0, 4);
    check("q_rdy_ex", bad_rdy, 0);
    check("q_ex_seen", ex_seen, 5);
    check("q_s0", stk_s0, 30);
    check("q_nos", mem[sp-2], 30);
    check("q_sp", sp, 7);
    check("q_depth", depth, CHK ? 7 : 0);

    // reset during EX2 of ADD
    issue(4'd5, 0);
    @(posedge clk);
    #1;
    check("ex2_cmd", stk_cmd, 3'b100);
    check("ex2_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_cmd", stk_cmd, 0);
    check("mid_busy", busy, 0);
    check("mid_in", stk_in, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_ready", op_ready, 1);
    check("post_depth", depth, 0);
    run(4'd1, 16'd9, cyc);
    check("post_s0", stk_s0, 9);
    check("post_depth1", depth, CHK ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
